// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA constants, opcode field position and fetch state encoding
package isa_pkg;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_IN  = 5'b01011;
   localparam logic [4:0] OP_OUT = 5'b01100;
   localparam logic [4:0] OP_HLT = 5'b01111;

   typedef enum logic [1:0] {
      FETCH_OP,
      FETCH_ARG,
      HOLD,
      HALT
   } fetch_state_t;

   // Only NOP and HLT carry no operand word.
   function automatic logic is_two_word(input logic [4:0] opcode);
      return !((opcode == OP_NOP) || (opcode == OP_HLT));
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage assembling one/two-word instruction bundles from RAM
module instr_fetch
   import isa_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_word,
   output logic [DATA_WIDTH-1:0] instr_operand,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  halted
);

   fetch_state_t          state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n, instr_pc_n;
   logic [DATA_WIDTH-1:0] word_n, operand_n;
   logic                  valid_n, halted_n;

   assign mem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FETCH_OP;
         pc            <= RESET_PC;
         instr_valid   <= 1'b0;
         instr_word    <= '0;
         instr_operand <= '0;
         instr_pc      <= RESET_PC;
         halted        <= 1'b0;
      end else begin
         state         <= state_n;
         pc            <= pc_n;
         instr_valid   <= valid_n;
         instr_word    <= word_n;
         instr_operand <= operand_n;
         instr_pc      <= instr_pc_n;
         halted        <= halted_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      valid_n    = instr_valid;
      word_n     = instr_word;
      operand_n  = instr_operand;
      instr_pc_n = instr_pc;
      halted_n   = halted;

      // Redirect beats everything outside HALT; a same-cycle handshake is already consumed.
      if (branch_en && (state != HALT)) begin
         pc_n    = branch_target;
         valid_n = 1'b0;
         state_n = FETCH_OP;
      end else begin
         case (state)
            FETCH_OP: begin
               word_n     = mem_q;
               instr_pc_n = pc;
               pc_n       = pc + ADDR_WIDTH'(1);
               operand_n  = '0;
               if (is_two_word(mem_q[OPC_MSB:OPC_LSB])) begin
                  state_n = FETCH_ARG;
               end else begin
                  state_n = HOLD;
                  valid_n = 1'b1;
               end
            end
            FETCH_ARG: begin
               operand_n = mem_q;
               pc_n      = pc + ADDR_WIDTH'(1);
               valid_n   = 1'b1;
               state_n   = HOLD;
            end
            HOLD: begin
               if (instr_valid && instr_ready) begin
                  valid_n = 1'b0;
                  if (instr_word[OPC_MSB:OPC_LSB] == OP_HLT) begin
                     state_n  = HALT;
                     halted_n = 1'b1;
                  end else begin
                     state_n = FETCH_OP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_q;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_word;
   logic [15:0] instr_operand;
   logic [15:0] instr_pc;
   logic        branch_en;
   logic [15:0] branch_target;
   logic        halted;

   logic [15:0] mem [0:65535];
   int          vectors = 0;
   int          miscompares = 0;
   int          accepted = 0;
   logic [15:0] exp_pc;
   logic [15:0] w;

   always #5 clk = ~clk;

   assign mem_q = mem[mem_addr];

   instr_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_addr(mem_addr),
      .mem_q(mem_q),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_word(instr_word),
      .instr_operand(instr_operand),
      .instr_pc(instr_pc),
      .branch_en(branch_en),
      .branch_target(branch_target),
      .halted(halted)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int instr_len(input logic [15:0] word);
      return (word[15:11] == 5'b00000 || word[15:11] == 5'b01111) ? 1 : 2;
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      rst_n = 1'b0;
      instr_ready = 1'b0;
      branch_en = 1'b0;
      branch_target = 16'h0000;
      mem[0] = 16'h5800; mem[1] = 16'h0064;
      mem[2] = 16'h6000; mem[3] = 16'h0065;
      mem[4] = 16'h5800; mem[5] = 16'hABCD;
      mem[8] = 16'h0000;
      mem[16] = 16'h7E00;
      mem[16'hFFFF] = 16'h5800;

      #2;
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_word", instr_word, 0);
      check_eq("rst_operand", instr_operand, 0);
      check_eq("rst_instr_pc", instr_pc, 0);
      check_eq("rst_halted", halted, 0);
      check_eq("rst_mem_addr", mem_addr, 0);

      instr_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      check_eq("in_edge1_valid", instr_valid, 0);
      check_eq("in_edge1_addr", mem_addr, 1);
      step();
      check_eq("in_valid", instr_valid, 1);
      check_eq("in_word", instr_word, 16'h5800);
      check_eq("in_operand", instr_operand, 16'h0064);
      check_eq("in_pc", instr_pc, 0);
      step();
      check_eq("in_accept_valid", instr_valid, 0);
      check_eq("in_accept_addr", mem_addr, 2);
      instr_ready = 1'b0;

      step();
      step();
      check_eq("out_valid", instr_valid, 1);
      check_eq("out_pc", instr_pc, 2);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("stall_valid", instr_valid, 1);
         check_eq("stall_word", instr_word, 16'h6000);
         check_eq("stall_operand", instr_operand, 16'h0065);
         check_eq("stall_addr", mem_addr, 4);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check_eq("out_accept_valid", instr_valid, 0);
      check_eq("out_accept_addr", mem_addr, 4);

      step();
      check_eq("arg_state_addr", mem_addr, 5);
      branch_en = 1'b1;
      branch_target = 16'h0008;
      step();
      branch_en = 1'b0;
      check_eq("br_valid", instr_valid, 0);
      check_eq("br_addr", mem_addr, 8);
      step();
      check_eq("br_nop_valid", instr_valid, 1);
      check_eq("br_nop_pc", instr_pc, 8);
      check_eq("br_nop_operand", instr_operand, 0);

      mem[0] = 16'h1234;
      instr_ready = 1'b1;
      branch_en = 1'b1;
      branch_target = 16'hFFFF;
      step();
      branch_en = 1'b0;
      instr_ready = 1'b0;
      check_eq("wrap_br_valid", instr_valid, 0);
      check_eq("wrap_br_addr", mem_addr, 16'hFFFF);
      step();
      check_eq("wrap_arg_addr", mem_addr, 0);
      step();
      check_eq("wrap_valid", instr_valid, 1);
      check_eq("wrap_word", instr_word, 16'h5800);
      check_eq("wrap_operand", instr_operand, 16'h1234);
      check_eq("wrap_pc", instr_pc, 16'hFFFF);
      check_eq("wrap_next_addr", mem_addr, 1);

      instr_ready = 1'b1;
      branch_en = 1'b1;
      branch_target = 16'd16;
      step();
      branch_en = 1'b0;
      check_eq("hlt_br_valid", instr_valid, 0);
      check_eq("hlt_br_addr", mem_addr, 16);
      step();
      check_eq("hlt_valid", instr_valid, 1);
      check_eq("hlt_word", instr_word, 16'h7E00);
      check_eq("hlt_operand", instr_operand, 0);
      check_eq("hlt_pc", instr_pc, 16);
      branch_en = 1'b1;
      step();
      branch_en = 1'b0;
      check_eq("hlt_br_wins_halted", halted, 0);
      check_eq("hlt_br_wins_addr", mem_addr, 16);
      step();
      check_eq("hlt_again_valid", instr_valid, 1);
      step();
      check_eq("halted_set", halted, 1);
      check_eq("halted_valid", instr_valid, 0);
      check_eq("halted_addr", mem_addr, 17);
      for (int i = 0; i < 20; i++) begin
         branch_en = 1'($urandom_range(0, 1));
         branch_target = 16'($urandom);
         instr_ready = 1'($urandom_range(0, 1));
         step();
         check_eq("halt_frozen_addr", mem_addr, 17);
         check_eq("halt_frozen_valid", instr_valid, 0);
         check_eq("halt_frozen_halted", halted, 1);
      end
      branch_en = 1'b0;

      rst_n = 1'b0;
      #2;
      check_eq("rst_from_halt", halted, 0);
      check_eq("rst_from_halt_addr", mem_addr, 0);
      mem[0] = 16'h5800;
      mem[1] = 16'h0064;
      instr_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      check_eq("pre_async_valid", instr_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("async_valid", instr_valid, 0);
      check_eq("async_addr", mem_addr, 0);
      check_eq("async_word", instr_word, 0);
      check_eq("async_pc", instr_pc, 0);

      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (w[15:11] == 5'b01111) w[15] = 1'b1;
         mem[i] = w;
      end
      step();
      rst_n = 1'b1;
      exp_pc = 16'h0000;
      for (int c = 0; c < 3000; c++) begin
         instr_ready = ($urandom_range(0, 9) < 7);
         branch_en = ($urandom_range(0, 19) == 0);
         branch_target = 16'($urandom_range(0, 250));
         if (instr_valid && instr_ready) begin
            check_eq("rnd_pc", instr_pc, exp_pc);
            check_eq("rnd_word", instr_word, mem[exp_pc]);
            check_eq("rnd_operand", instr_operand,
                     (instr_len(mem[exp_pc]) == 2) ? mem[16'(exp_pc + 16'd1)] : 16'h0000);
            exp_pc = 16'(exp_pc + 16'(instr_len(mem[exp_pc])));
            accepted++;
         end
         if (branch_en) exp_pc = branch_target;
         step();
      end
      instr_ready = 1'b0;
      branch_en = 1'b0;
      check_eq("rnd_progress", (accepted >= 100), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
